// File: rtl/fib_stream_serializer_if.sv
// Output stream bundle of the Fibonacci frame serializer.
// Carries term, tag, handshake and frame status signals.
interface fib_stream_serializer_if #(
  parameter int F = 10,
  parameter int W = 32
);
  localparam int IW = $clog2(F);

  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_ovf;
  logic          done;
  logic          frame_ovf;

  modport master (
    output busy, out_valid, out_data, out_index,
    output out_last, out_ovf, done, frame_ovf,
    input  out_ready
  );

  modport slave (
    input  busy, out_valid, out_data, out_index,
    input  out_last, out_ovf, done, frame_ovf,
    output out_ready
  );
endinterface

// File: rtl/fib_stream_serializer.sv
// Snapshots a parallel Fibonacci frame and streams it term by term.
// Each term carries its index, last flag and wrap-around flag.
module fib_stream_serializer #(
  parameter int F = 10,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] fib_in [0:F-1],
  input  logic         start,
  fib_stream_serializer_if.master o
);
  localparam int IW = $clog2(F);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  fbuf_q [0:F-1];
  logic [W-1:0]  fbuf_d [0:F-1];
  logic [IW-1:0] idx_q, idx_d;
  logic          fovf_q, fovf_d;

  logic          ge2;
  logic          last;
  logic          hs;
  logic          ovf;
  logic [IW-1:0] im1, im2;
  logic [W:0]    sum;

  // Single shared adder recomputes the carry of the two preceding terms.
  always_comb begin
    ge2  = 32'(idx_q) >= 32'd2;
    last = idx_q == IW'(F - 1);
    hs   = (state_q == STREAM) && o.out_ready;
    im1  = ge2 ? idx_q - IW'(1) : '0;
    im2  = ge2 ? idx_q - IW'(2) : '0;
    sum  = {1'b0, fbuf_q[im1]} + {1'b0, fbuf_q[im2]};
    ovf  = ge2 && sum[W];
  end

  // Next-state logic: capture on start, advance on handshake.
  always_comb begin
    state_d = state_q;
    fbuf_d  = fbuf_q;
    idx_d   = idx_q;
    fovf_d  = fovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          fbuf_d  = fib_in;
          idx_d   = '0;
          fovf_d  = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          fovf_d = fovf_q | ovf;
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, frame buffer, index and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fovf_q  <= 1'b0;
      for (int i = 0; i < F; i++) begin
        fbuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fovf_q  <= fovf_d;
      fbuf_q  <= fbuf_d;
    end
  end

  // Outputs decode from registered state only; out_ready never reaches out_valid.
  always_comb begin
    o.busy      = state_q != IDLE;
    o.out_valid = state_q == STREAM;
    o.out_data  = '0;
    o.out_index = '0;
    o.out_last  = 1'b0;
    o.out_ovf   = 1'b0;
    if (state_q == STREAM) begin
      o.out_data  = fbuf_q[idx_q];
      o.out_index = idx_q;
      o.out_last  = last;
      o.out_ovf   = ovf;
    end
    o.done      = state_q == DONE;
    o.frame_ovf = fovf_q;
  end
endmodule

// File: tb/tb_fib_stream_serializer.sv
// Directed scoreboard bench for fib_stream_serializer.
// Three instances cover F=10, F=4 and F=2.
module tb_fib_stream_serializer;
  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic start_a, start_b, start_c;
  logic [31:0] fib_a [0:9];
  logic [31:0] fib_b [0:3];
  logic [31:0] fib_c [0:1];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
    logic        v;
  } term_t;

  term_t qa[$];
  term_t qb[$];
  term_t qc[$];

  always #5 clk = ~clk;

  fib_stream_serializer_if #(.F(10), .W(32)) ia ();
  fib_stream_serializer_if #(.F(4), .W(32))  ib ();
  fib_stream_serializer_if #(.F(2), .W(32))  ic ();

  assign ia.out_ready = ready;
  assign ib.out_ready = ready;
  assign ic.out_ready = ready;

  fib_stream_serializer #(.F(10), .W(32)) u_a (
    .clk(clk), .rst(rst), .fib_in(fib_a), .start(start_a), .o(ia)
  );
  fib_stream_serializer #(.F(4), .W(32)) u_b (
    .clk(clk), .rst(rst), .fib_in(fib_b), .start(start_b), .o(ib)
  );
  fib_stream_serializer #(.F(2), .W(32)) u_c (
    .clk(clk), .rst(rst), .fib_in(fib_c), .start(start_c), .o(ic)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Generator model: series with 32-bit wrap and per-term carry.
  task automatic frame(input int k, input logic [31:0] s0,
                       input logic [31:0] s1, input bit drv,
                       input bit psh);
    int n;
    logic [31:0] t [10];
    logic c [10];
    term_t e;
    n = (k == 0) ? 10 : (k == 1) ? 4 : 2;
    t[0] = s0;
    t[1] = s1;
    c[0] = 1'b0;
    c[1] = 1'b0;
    for (int i = 2; i < n; i++) begin
      {c[i], t[i]} = {1'b0, t[i-1]} + {1'b0, t[i-2]};
    end
    for (int i = 0; i < n; i++) begin
      if (drv) begin
        if (k == 0) fib_a[i] = t[i];
        else if (k == 1) fib_b[i] = t[i];
        else fib_c[i] = t[i];
      end
      if (psh) begin
        e = {t[i], 4'(i), i == n - 1, c[i]};
        if (k == 0) qa.push_back(e);
        else if (k == 1) qb.push_back(e);
        else qc.push_back(e);
      end
    end
  endtask

  function automatic logic done_of(input int k);
    if (k == 0) return ia.done;
    if (k == 1) return ib.done;
    return ic.done;
  endfunction

  task automatic pulse(input int k);
    @(posedge clk); #1;
    if (k == 0) start_a = 1'b1;
    else if (k == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Cycles from first valid cycle until done; ends on a falling edge.
  task automatic wait_done(input int k, input int mode, output int n);
    n = 0;
    while (n < 200) begin
      ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      @(negedge clk);
      if (done_of(k)) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pop_exp(input int k, output term_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (k == 0 && qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
    if (k == 1 && qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
    if (k == 2 && qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
  endtask

  term_t prev [3];
  bit    held [3] = '{0, 0, 0};

  // Monitor: scoreboard pops on handshake, stability while stalled.
  always @(negedge clk) begin
    term_t obs [3];
    logic  vld [3];
    term_t e;
    bit    ok;
    obs[0] = {ia.out_data, 4'(ia.out_index), ia.out_last, ia.out_ovf};
    obs[1] = {ib.out_data, 4'(ib.out_index), ib.out_last, ib.out_ovf};
    obs[2] = {ic.out_data, 4'(ic.out_index), ic.out_last, ic.out_ovf};
    vld[0] = ia.out_valid;
    vld[1] = ib.out_valid;
    vld[2] = ic.out_valid;
    for (int k = 0; k < 3; k++) begin
      if (vld[k] === 1'b1) begin
        if (held[k]) chk($sformatf("hold%0d", k), obs[k], prev[k]);
        if (ready) begin
          pop_exp(k, e, ok);
          if (ok) chk($sformatf("term%0d_%0d", k, e.i), obs[k], e);
          else chk($sformatf("unexp%0d", k), vld[k], 1'b0);
          held[k] = 1'b0;
        end else begin
          held[k] = 1'b1;
          prev[k] = obs[k];
        end
      end else begin
        held[k] = 1'b0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    ready = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    frame(0, 0, 0, 1, 0);
    frame(1, 0, 0, 1, 0);
    frame(2, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", ia.busy, 0);
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_fovf", ia.frame_ovf, 0);
    chk("rst_data", ia.out_data, 0);
    chk("rst_index", ia.out_index, 0);
    chk("rst_valid_b", ib.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    frame(0, 0, 1, 1, 1);
    pulse(0);
    wait_done(0, 0, n);
    chk("a_done_n", n, 10);
    chk("a_done_busy", ia.busy, 1);
    chk("a_done_fovf", ia.frame_ovf, 0);
    chk("a_done_valid", ia.out_valid, 0);
    @(negedge clk);
    chk("a_idle_busy", ia.busy, 0);
    chk("a_idle_done", ia.done, 0);
    chk("a_q_empty1", qa.size(), 0);

    frame(0, 0, 1, 0, 1);
    pulse(0);
    wait_done(0, 1, n);
    chk("a_stall_done_n", n, 28);
    chk("a_q_empty2", qa.size(), 0);
    ready = 1'b1;

    frame(1, 32'h8000_0000, 32'h8000_0000, 1, 1);
    pulse(1);
    wait_done(1, 0, n);
    chk("b_done_n", n, 4);
    chk("b_fovf_done", ib.frame_ovf, 1);
    repeat (3) @(negedge clk);
    chk("b_fovf_held", ib.frame_ovf, 1);
    frame(1, 0, 1, 1, 1);
    pulse(1);
    @(negedge clk);
    chk("b_fovf_clr", ib.frame_ovf, 0);
    @(posedge clk); #1;
    wait_done(1, 0, n);
    chk("b2_done_n", n, 3);
    chk("b2_fovf", ib.frame_ovf, 0);

    frame(0, 0, 1, 1, 1);
    pulse(0);
    n = 0;
    while (n < 50) begin
      if (n == 3) begin
        start_a = 1'b1;
        frame(0, 2, 3, 1, 0);
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      if (ia.done) break;
      @(posedge clk); #1;
      n++;
    end
    chk("a_rep_done_n", n, 10);
    start_a = 1'b1;
    @(posedge clk); #1;
    frame(0, 2, 3, 0, 1);
    @(negedge clk);
    chk("a_rep_idle_busy", ia.busy, 0);
    chk("a_rep_idle_valid", ia.out_valid, 0);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(0, 0, n);
    chk("a_new_done_n", n, 10);
    chk("a_q_empty3", qa.size(), 0);

    frame(0, 0, 1, 1, 1);
    pulse(0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("a_pre_rst_idx", ia.out_index, 4);
    #2 rst = 1'b1;
    #1;
    chk("a_arst_valid", ia.out_valid, 0);
    chk("a_arst_data", ia.out_data, 0);
    chk("a_arst_index", ia.out_index, 0);
    chk("a_arst_busy", ia.busy, 0);
    qa.delete();
    repeat (2) begin
      @(negedge clk);
      chk("a_rst_done", ia.done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("a_post_rst_done", ia.done, 0);
    end
    frame(0, 0, 1, 1, 1);
    pulse(0);
    wait_done(0, 0, n);
    chk("a_post_rst_n", n, 10);

    frame(2, 7, 9, 1, 1);
    pulse(2);
    wait_done(2, 0, n);
    chk("c_done_n", n, 2);
    chk("c_fovf", ic.frame_ovf, 0);

    @(negedge clk);
    chk("qa_end", qa.size(), 0);
    chk("qb_end", qb.size(), 0);
    chk("qc_end", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
